bus_xchg_reg: RTL and testbench

//  Registered, parametrised bidirectional exchange between two tri-state buses A and B.

---
 rtl/bus_xchg_reg_pkg.sv | 25 ++
 rtl/bus_xchg_reg_turn_timer.sv | 27 ++
 rtl/bus_xchg_reg.sv | 149 ++++++++++++++
 tb/tb_bus_xchg_reg.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/bus_xchg_reg_pkg.sv
// Shared encodings and payload types for the registered A/B bus exchanger.
package bus_xchg_reg_pkg;

    localparam int unsigned DEF_WIDTH       = 16;
    localparam int unsigned DEF_TURN_CYCLES = 2;
    localparam int unsigned DEF_CNT_W       = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRV_AB = 2'd1,
        ST_DRV_BA = 2'd2,
        ST_TURN   = 2'd3
    } state_e;

    localparam logic DIR_AB = 1'b0;
    localparam logic DIR_BA = 1'b1;

    // Registered control outputs, updated together every edge.
    typedef struct packed {
        logic oe_a;
        logic oe_b;
        logic busy;
    } ctl_t;

endpackage

// File: rtl/bus_xchg_reg_turn_timer.sv
// Turnaround dead-time counter: load, saturating decrement, zero flag.
module turn_timer #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero_c
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/bus_xchg_reg.sv
// Registered bidirectional exchange between tri-state buses A and B with an
// enforced hi-Z turnaround on every direction change.
module bus_xchg_reg
    import bus_xchg_reg_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned TURN_CYCLES = DEF_TURN_CYCLES,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir_req,
    input  logic             hold,
    inout  wire  [WIDTH-1:0] busa,
    inout  wire  [WIDTH-1:0] busb,
    output logic             oe_a,
    output logic             oe_b,
    output logic             busy
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic             r_tgt_dir;
    logic             w_tgt_nxt;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_data_nxt;
    ctl_t             r_ctl;
    ctl_t             w_ctl_nxt;
    logic             w_tmr_load;
    logic             w_tmr_dec;
    logic             w_tmr_zero_c;

    turn_timer #(
        .CNT_W (CNT_W)
    ) u_turn_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (CNT_W'(TURN_CYCLES - 1)),
        .i_dec      (w_tmr_dec),
        .o_zero_c   (w_tmr_zero_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_tgt_dir <= DIR_AB;
            r_data    <= '0;
            r_ctl     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_tgt_dir <= w_tgt_nxt;
            r_data    <= w_data_nxt;
            r_ctl     <= w_ctl_nxt;
        end
    end

    // Next state, data capture and next-cycle drive enables; drive is off unless a state asserts it.
    always_comb begin
        w_state_nxt = r_state;
        w_tgt_nxt   = r_tgt_dir;
        w_data_nxt  = r_data;
        w_ctl_nxt   = '0;
        w_tmr_load  = 1'b0;
        w_tmr_dec   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_tgt_nxt = dir_req;
                    if (dir_req == DIR_BA) begin
                        w_state_nxt    = ST_DRV_BA;
                        w_ctl_nxt.oe_a = 1'b1;
                        if (!hold) w_data_nxt = busb;
                    end else begin
                        w_state_nxt    = ST_DRV_AB;
                        w_ctl_nxt.oe_b = 1'b1;
                        if (!hold) w_data_nxt = busa;
                    end
                end
            end

            ST_DRV_AB: begin
                if (!en) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    if (!hold) w_data_nxt = busa;
                    if (dir_req != DIR_AB) begin
                        w_state_nxt    = ST_TURN;
                        w_tgt_nxt      = DIR_BA;
                        w_tmr_load     = 1'b1;
                        w_ctl_nxt.busy = 1'b1;
                    end else begin
                        w_ctl_nxt.oe_b = 1'b1;
                    end
                end
            end

            ST_DRV_BA: begin
                if (!en) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    if (!hold) w_data_nxt = busb;
                    if (dir_req != DIR_BA) begin
                        w_state_nxt    = ST_TURN;
                        w_tgt_nxt      = DIR_AB;
                        w_tmr_load     = 1'b1;
                        w_ctl_nxt.busy = 1'b1;
                    end else begin
                        w_ctl_nxt.oe_a = 1'b1;
                    end
                end
            end

            ST_TURN: begin
                // dir_req is deliberately ignored here; the target was latched on entry.
                if (!en) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_tmr_zero_c) begin
                    if (r_tgt_dir == DIR_BA) begin
                        w_state_nxt    = ST_DRV_BA;
                        w_ctl_nxt.oe_a = 1'b1;
                        if (!hold) w_data_nxt = busb;
                    end else begin
                        w_state_nxt    = ST_DRV_AB;
                        w_ctl_nxt.oe_b = 1'b1;
                        if (!hold) w_data_nxt = busa;
                    end
                end else begin
                    w_tmr_dec      = 1'b1;
                    w_ctl_nxt.busy = 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign oe_a = r_ctl.oe_a;
    assign oe_b = r_ctl.oe_b;
    assign busy = r_ctl.busy;

    assign busa = r_ctl.oe_a ? r_data : {WIDTH{1'bz}};
    assign busb = r_ctl.oe_b ? r_data : {WIDTH{1'bz}};

endmodule

// File: tb/tb_bus_xchg_reg.sv
// Scoreboard bench for bus_xchg_reg: directed steps push expected outputs,
// a monitor pops and compares one entry after every clock edge.
module tb_bus_xchg_reg;

    typedef struct {
        string       name;
        logic        oe_a;
        logic        oe_b;
        logic        busy;
        logic [15:0] busa;
        logic [15:0] busb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        dir_req = 1'b0;
    logic        hold = 1'b0;
    logic        a_drv = 1'b0;
    logic        b_drv = 1'b0;
    logic [15:0] a_val = 16'h0000;
    logic [15:0] b_val = 16'h0000;
    logic        oe_a;
    logic        oe_b;
    logic        busy;
    tri1  [15:0] busa;
    tri1  [15:0] busb;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    bit   mon_on = 1'b0;

    assign busa = a_drv ? a_val : 16'hzzzz;
    assign busb = b_drv ? b_val : 16'hzzzz;

    always #5 clk = ~clk;

    bus_xchg_reg #(
        .WIDTH       (16),
        .TURN_CYCLES (2),
        .CNT_W       (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .dir_req (dir_req),
        .hold    (hold),
        .busa    (busa),
        .busb    (busb),
        .oe_a    (oe_a),
        .oe_b    (oe_b),
        .busy    (busy)
    );

    // Monitor: compare DUT state just after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (mon_on) begin
            n_checks++;
            if (oe_a && oe_b) begin
                n_fail++;
                $display("FAIL overlap: oe_a=%b oe_b=%b required never both 1", oe_a, oe_b);
            end
        end
        if (q.size() > 0) begin
            e = q.pop_front();
            n_checks++;
            if (oe_a !== e.oe_a || oe_b !== e.oe_b || busy !== e.busy ||
                busa !== e.busa || busb !== e.busb) begin
                n_fail++;
                $display("FAIL %s: got oe_a=%b oe_b=%b busy=%b busa=%h busb=%h required oe_a=%b oe_b=%b busy=%b busa=%h busb=%h",
                         e.name, oe_a, oe_b, busy, busa, busb,
                         e.oe_a, e.oe_b, e.busy, e.busa, e.busb);
            end
        end
    end

    // Apply inputs on the falling edge and queue the state expected after the next rising edge.
    task automatic step(input string nm, input logic r, input logic e, input logic d,
                        input logic h, input logic ad, input logic [15:0] av,
                        input logic bd, input logic [15:0] bv,
                        input logic x_oa, input logic x_ob, input logic x_bz,
                        input logic [15:0] x_a, input logic [15:0] x_b);
        exp_t ex;
        @(negedge clk);
        rst = r; en = e; dir_req = d; hold = h;
        a_drv = ad; a_val = av; b_drv = bd; b_val = bv;
        ex.name = nm; ex.oe_a = x_oa; ex.oe_b = x_ob; ex.busy = x_bz;
        ex.busa = x_a; ex.busb = x_b;
        q.push_back(ex);
        mon_on = 1'b1;
        @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        //    name          rst en dir hld aD aV        bD bV        oeA oeB bsy busa      busb
        step("reset1",      1, 1, 0, 0,  0, 16'h0000, 0, 16'h0000, 0,  0,  0,  16'hFFFF, 16'hFFFF);
        step("reset2",      1, 1, 0, 0,  0, 16'h0000, 0, 16'h0000, 0,  0,  0,  16'hFFFF, 16'hFFFF);
        step("fwd_first",   0, 1, 0, 0,  1, 16'hA5C3, 0, 16'h0000, 0,  1,  0,  16'hA5C3, 16'hA5C3);
        step("fwd_next",    0, 1, 0, 0,  1, 16'h1234, 0, 16'h0000, 0,  1,  0,  16'h1234, 16'h1234);
        step("turn_enter",  0, 1, 1, 0,  1, 16'h1234, 0, 16'h0000, 0,  0,  1,  16'h1234, 16'hFFFF);
        step("turn_cyc2",   0, 1, 1, 0,  0, 16'h0000, 1, 16'h0F0F, 0,  0,  1,  16'hFFFF, 16'h0F0F);
        step("turn_exit",   0, 1, 1, 0,  0, 16'h0000, 1, 16'h0F0F, 1,  0,  0,  16'h0F0F, 16'h0F0F);
        step("back_enter",  0, 1, 0, 0,  0, 16'h0000, 1, 16'h0F0F, 0,  0,  1,  16'hFFFF, 16'h0F0F);
        step("back_cyc2",   0, 1, 0, 0,  1, 16'h5555, 0, 16'h0000, 0,  0,  1,  16'h5555, 16'hFFFF);
        step("back_exit",   0, 1, 0, 0,  1, 16'h5555, 0, 16'h0000, 0,  1,  0,  16'h5555, 16'h5555);
        step("hold_1",      0, 1, 0, 1,  1, 16'h1111, 0, 16'h0000, 0,  1,  0,  16'h1111, 16'h5555);
        step("hold_2",      0, 1, 0, 1,  1, 16'h2222, 0, 16'h0000, 0,  1,  0,  16'h2222, 16'h5555);
        step("hold_3",      0, 1, 0, 1,  1, 16'h3333, 0, 16'h0000, 0,  1,  0,  16'h3333, 16'h5555);
        step("hold_release",0, 1, 0, 0,  1, 16'h3333, 0, 16'h0000, 0,  1,  0,  16'h3333, 16'h3333);
        step("follow",      0, 1, 0, 0,  1, 16'h4444, 0, 16'h0000, 0,  1,  0,  16'h4444, 16'h4444);
        step("t2_enter",    0, 1, 1, 0,  1, 16'h4444, 0, 16'h0000, 0,  0,  1,  16'h4444, 16'hFFFF);
        step("t2_toggle",   0, 1, 0, 0,  0, 16'h0000, 1, 16'h9999, 0,  0,  1,  16'hFFFF, 16'h9999);
        step("t2_exit_ba",  0, 1, 0, 0,  0, 16'h0000, 1, 16'h9999, 1,  0,  0,  16'h9999, 16'h9999);
        step("t3_enter",    0, 1, 0, 0,  0, 16'h0000, 1, 16'h9999, 0,  0,  1,  16'hFFFF, 16'h9999);
        step("t3_abort",    0, 0, 0, 0,  0, 16'h0000, 0, 16'h0000, 0,  0,  0,  16'hFFFF, 16'hFFFF);
        step("idle_stay",   0, 0, 1, 0,  0, 16'h0000, 1, 16'h7777, 0,  0,  0,  16'hFFFF, 16'h7777);
        step("ba_start",    0, 1, 1, 0,  0, 16'h0000, 1, 16'hBEEF, 1,  0,  0,  16'hBEEF, 16'hBEEF);
        step("ba_steady",   0, 1, 1, 0,  0, 16'h0000, 1, 16'hBEEF, 1,  0,  0,  16'hBEEF, 16'hBEEF);
        step("rst_mid",     1, 1, 1, 0,  0, 16'h0000, 0, 16'h0000, 0,  0,  0,  16'hFFFF, 16'hFFFF);
        step("data_cleared",0, 1, 1, 1,  0, 16'h0000, 0, 16'h0000, 1,  0,  0,  16'h0000, 16'hFFFF);
        step("release",     0, 0, 1, 0,  0, 16'h0000, 0, 16'h0000, 0,  0,  0,  16'hFFFF, 16'hFFFF);

        @(negedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending entries required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
